exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage pipelined MIPS CPU. It consumes the ID/EXE pipeline-register outputs and computes the ALU result, jal link address and destination register, and registers them into the EXE/MEM boundary. An iterative multiplier stalls the upstream stages while it runs.

## Interface
Parameters:
- none

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ea  input  32  register operand A
- eb  input  32  register operand B; also the store data
- eimm  input  32  extended immediate; eimm[10:6] is the shift amount
- epc4  input  32  PC+4 of the instruction
- ern  input  5  destination register from ID
- ealuc  input  4  ALU operation code
- ewreg, em2reg, ewmem, ealuimm, eshift, ejal  input  1 each  control bits from ID
- ealu_fwd  output  32  combinational EXE result, used for ID forwarding
- ern_fwd  output  5  effective destination (31 when ejal), used for forwarding
- exe_stall  output  1  hold PC, IF/ID and ID/EXE; combinational
- mwreg, mm2reg, mwmem  output  1 each  registered control bits
- malu  output  32  registered result
- mb  output  32  registered store data (eb)
- mrn  output  5  registered destination

## Operation
- Operand A is {27'b0, eimm[10:6]} when eshift=1, otherwise ea.
- Operand B is eimm when ealuimm=1, otherwise eb.
- ealuc decode: x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR, x110 LUI (B<<16), 0011 SLL, 0111 SRL, 1111 SRA (shift B by A[4:0]), 1011 MUL (low 32 bits of A*B).
- Other codes produce 0.
- All arithmetic is 32-bit and wraps. No overflow trap.
- When ejal=1, the result is epc4+4 and the destination is forced to 31.
- Multiplier FSM, with states IDLE, BUSY and DONE:
  - IDLE with ealuc=1011: load multiplicand and multiplier, clear the product, set count=0, go to BUSY.
  - BUSY: one shift-add step per cycle, count+1. After step 32 (count=31), go to DONE.
  - DONE: product is valid. Go to IDLE unconditionally.
- exe_stall is 1 in (IDLE and ealuc=1011) or in BUSY. It is 0 in DONE and otherwise.
- Upstream holds its contents while exe_stall=1.
- While exe_stall=1, the EXE/MEM register loads a bubble: mwreg=mwmem=mm2reg=0, and malu, mb, mrn hold their previous values.
- In DONE, the EXE/MEM register loads the product and the control bits of the held MUL instruction.
- Non-MUL instructions pass every cycle with no stall.

## Timing
- Reset (asynchronous): state IDLE, count 0, product 0, mwreg=mm2reg=mwmem=0, malu=0, mb=0, mrn=0.
  - exe_stall follows its equation. It is 0 unless ealuc=1011.
- Reset mid-multiply aborts the operation. No result is written.
- Non-MUL latency: 1 cycle. Outputs appear on the edge after the inputs.
- MUL:
  - Detect cycle T: stall=1.
  - BUSY for T+1..T+32: stall=1.
  - DONE at T+33: stall=0. The EXE/MEM register captures at the end of T+33.
  - The next instruction enters EXE at T+34.
- A MUL immediately following a MUL: the second is detected in IDLE at T+34. There is no dead cycle.
- ealu_fwd is valid only when exe_stall=0.

## Configuration
- EXE_MULT_EN defined: multiplier FSM, counter and the MUL decode are present as above.
- EXE_MULT_EN undefined:
  - No FSM.
  - exe_stall is tied to 0.
  - ealuc=1011 produces result 0 in one cycle, like any other undefined code.

## Test plan
- Reset low mid-test -> all m* outputs 0 immediately. After release, ADD ea=5, eb=7, ealuc=0000 -> malu=12, mrn=ern next edge.
- SUB with ea=3, eb=5 -> malu=0xFFFFFFFE. SRA with eshift=1, eimm[10:6]=4, eb=0x80000000 -> malu=0xF8000000.
- jal: ejal=1, epc4=0x00400010, ern=0 -> malu=0x00400014, mrn=31, ern_fwd=31.
- MUL (EXE_MULT_EN): ea=0x0001_0003, eb=0x0000_0100 -> exe_stall=1 for exactly 33 cycles, 33 bubbles with mwreg=0, then malu=0x0100_0300 with mwreg=1.
- MUL with rst_n pulsed at BUSY count 10 -> state IDLE, mwreg=0. Held MUL re-detected and completes 33 stall cycles after release.
- EXE_MULT_EN undefined: ealuc=1011, ea=2, eb=3 -> exe_stall stays 0, malu=0 next edge.

Source files
------------

// File: rtl/exe_stage_if.sv
// ID/EXE operand/control bundle and EXE/MEM register outputs of the execute stage.
// mul_state mirrors the multiplier FSM (0 IDLE, 1 BUSY, 2 DONE) for observation.
interface exe_stage_if;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [31:0] epc4;
  logic [4:0]  ern;
  logic [3:0]  ealuc;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [31:0] ealu_fwd;
  logic [4:0]  ern_fwd;
  logic        exe_stall;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mrn;
  logic [1:0]  mul_state;

  modport master (
    output ea, eb, eimm, epc4, ern, ealuc, ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
    input  ealu_fwd, ern_fwd, exe_stall, mwreg, mm2reg, mwmem, malu, mb, mrn, mul_state
  );

  modport slave (
    input  ea, eb, eimm, epc4, ern, ealuc, ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
    output ealu_fwd, ern_fwd, exe_stall, mwreg, mm2reg, mwmem, malu, mb, mrn, mul_state
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, jal link, EXE/MEM register and an iterative multiplier.
// Define EXE_MULT_EN to build the multiplier FSM; otherwise MUL (1011) yields 0 with no stall.
module exe_stage (
    input logic   clk,
    input logic   rst_n,
    exe_stage_if.slave bus
);

    localparam logic [3:0] ALUC_MUL = 4'b1011;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] ealu;
    logic        stall;

    assign alu_a = bus.eshift  ? {27'b0, bus.eimm[10:6]} : bus.ea;
    assign alu_b = bus.ealuimm ? bus.eimm : bus.eb;

    always_comb begin
        alu_res = '0;
        casez (bus.ealuc)
            4'b?000: alu_res = alu_a + alu_b;
            4'b?100: alu_res = alu_a - alu_b;
            4'b?001: alu_res = alu_a & alu_b;
            4'b?101: alu_res = alu_a | alu_b;
            4'b?010: alu_res = alu_a ^ alu_b;
            4'b?110: alu_res = alu_b << 16;
            4'b0011: alu_res = alu_b << alu_a[4:0];
            4'b0111: alu_res = alu_b >> alu_a[4:0];
            4'b1111: alu_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            default: alu_res = '0;  // MUL result comes from the multiplier, not here
        endcase
    end

`ifdef EXE_MULT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t  state;
    mul_state_t  state_nxt;
    logic [4:0]  count;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] product;
    logic        is_mul;

    assign is_mul = (bus.ealuc == ALUC_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    state_nxt = BUSY;
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (count == 5'd31) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift-add over the low 32 bits only; upper product bits are never needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (state == IDLE && is_mul) begin
            count   <= '0;
            mcand   <= alu_a;
            mplier  <= alu_b;
            product <= '0;
        end else if (state == BUSY) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
        end
    end

    assign ealu          = bus.ejal ? (bus.epc4 + 32'd4) : (is_mul ? product : alu_res);
    assign bus.mul_state = state;
`else
    assign stall         = 1'b0;
    assign ealu          = bus.ejal ? (bus.epc4 + 32'd4) : alu_res;
    assign bus.mul_state = 2'd0;
`endif

    // exe_stall=1 means the upstream stages must hold their registers this cycle;
    // EXE/MEM then takes a bubble and the held instruction is re-presented next cycle.
    assign bus.exe_stall = stall;
    assign bus.ealu_fwd  = ealu;
    assign bus.ern_fwd   = bus.ejal ? 5'd31 : bus.ern;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mwreg  <= 1'b0;
            bus.mm2reg <= 1'b0;
            bus.mwmem  <= 1'b0;
            bus.malu   <= '0;
            bus.mb     <= '0;
            bus.mrn    <= '0;
        end else if (stall) begin
            bus.mwreg  <= 1'b0;
            bus.mm2reg <= 1'b0;
            bus.mwmem  <= 1'b0;
        end else begin
            bus.mwreg  <= bus.ewreg;
            bus.mm2reg <= bus.em2reg;
            bus.mwmem  <= bus.ewmem;
            bus.malu   <= ealu;
            bus.mb     <= bus.eb;
            bus.mrn    <= bus.ern_fwd;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage; MUL scenarios are built only when EXE_MULT_EN is defined.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exe_stage_if bus ();

  exe_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_mb_q[$];
  logic [4:0]  exp_rn_q[$];
  logic [2:0]  exp_ctl_q[$];

  function automatic logic [31:0] model(input logic [31:0] a, b, imm, pc4,
                                        input logic [3:0] aluc,
                                        input logic aluimm, shift, jal);
    logic [31:0] x;
    logic [31:0] y;
    x = shift ? {27'b0, imm[10:6]} : a;
    y = aluimm ? imm : b;
    if (jal) return pc4 + 32'd4;
    case (aluc)
      4'b0000, 4'b1000: return x + y;
      4'b0100, 4'b1100: return x - y;
      4'b0001, 4'b1001: return x & y;
      4'b0101, 4'b1101: return x | y;
      4'b0010, 4'b1010: return x ^ y;
      4'b0110, 4'b1110: return {y[15:0], 16'h0000};
      4'b0011: return y << x[4:0];
      4'b0111: return y >> x[4:0];
      4'b1111: return $unsigned($signed(y) >>> x[4:0]);
`ifdef EXE_MULT_EN
      4'b1011: return x * y;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, b, imm, pc4, input logic [4:0] rn,
                       input logic [3:0] aluc, input logic [5:0] ctl);
    bus.ea = a; bus.eb = b; bus.eimm = imm; bus.epc4 = pc4; bus.ern = rn; bus.ealuc = aluc;
    {bus.ewreg, bus.em2reg, bus.ewmem, bus.ealuimm, bus.eshift, bus.ejal} = ctl;
  endtask

  // ctl = {wreg, m2reg, wmem, aluimm, shift, jal}; one non-stalling op, checked on the next edge
  task automatic issue(input logic [31:0] a, b, imm, pc4, input logic [4:0] rn,
                       input logic [3:0] aluc, input logic [5:0] ctl, input string name);
    logic [31:0] e_alu, e_mb;
    logic [4:0]  e_rn;
    logic [2:0]  e_ctl;
    drive(a, b, imm, pc4, rn, aluc, ctl);
    exp_q.push_back(model(a, b, imm, pc4, aluc, ctl[2], ctl[1], ctl[0]));
    exp_mb_q.push_back(b);
    exp_rn_q.push_back(ctl[0] ? 5'd31 : rn);
    exp_ctl_q.push_back(ctl[5:3]);
    @(posedge clk); #1;
    e_alu = exp_q.pop_front();
    e_mb  = exp_mb_q.pop_front();
    e_rn  = exp_rn_q.pop_front();
    e_ctl = exp_ctl_q.pop_front();
    total++;
    if (bus.malu !== e_alu) begin
      bad++; $display("FAIL %s malu: got %h want %h", name, bus.malu, e_alu);
    end
    total++;
    if (bus.mrn !== e_rn) begin
      bad++; $display("FAIL %s mrn: got %0d want %0d", name, bus.mrn, e_rn);
    end
    total++;
    if ({bus.mwreg, bus.mm2reg, bus.mwmem} !== e_ctl) begin
      bad++; $display("FAIL %s mctl: got %b want %b", name, {bus.mwreg, bus.mm2reg, bus.mwmem}, e_ctl);
    end
    total++;
    if (bus.mb !== e_mb) begin
      bad++; $display("FAIL %s mb: got %h want %h", name, bus.mb, e_mb);
    end
  endtask

  task automatic test_reset();
    issue(32'd1, 32'd1, 32'd0, 32'd0, 5'd9, 4'b0000, 6'b111000, "preload");
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.mwreg, bus.mm2reg, bus.mwmem} !== 3'b000 || bus.malu !== 32'h0 ||
        bus.mb !== 32'h0 || bus.mrn !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b malu=%h mb=%h mrn=%0d want all 0",
               {bus.mwreg, bus.mm2reg, bus.mwmem}, bus.malu, bus.mb, bus.mrn);
    end
    total++;
    if (bus.exe_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", bus.exe_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 4'b0000, 6'b100000, "add_after_reset");
  endtask

  task automatic test_arith();
    issue(32'd3, 32'd5, 32'd0, 32'd0, 5'd4, 4'b0100, 6'b100000, "sub");
    issue(32'd0, 32'h8000_0000, 32'd4 << 6, 32'd0, 5'd5, 4'b1111, 6'b100010, "sra");
    issue(32'd0, 32'd0, 32'h0000_1234, 32'd0, 5'd6, 4'b0110, 6'b100100, "lui");
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 5'd7, 4'b0001, 6'b100000, "and");
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 5'd8, 4'b0101, 6'b100000, "or");
    issue(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd9, 4'b0000, 6'b100000, "add_wrap");
    issue(32'd0, 32'h0000_0001, 32'd31 << 6, 32'd0, 5'd10, 4'b0011, 6'b100010, "sll31");
    issue(32'd0, 32'h1234_5678, 32'd0, 32'd0, 5'd11, 4'b1000, 6'b010000, "sw_store");
  endtask

  task automatic test_jal();
    drive(32'd0, 32'd0, 32'd0, 32'h0040_0010, 5'd0, 4'b0000, 6'b100001);
    #1;
    total++;
    if (bus.ern_fwd !== 5'd31) begin
      bad++; $display("FAIL jal_ern_fwd: got %0d want 31", bus.ern_fwd);
    end
    total++;
    if (bus.ealu_fwd !== 32'h0040_0014) begin
      bad++; $display("FAIL jal_fwd: got %h want 00400014", bus.ealu_fwd);
    end
    issue(32'd0, 32'd0, 32'd0, 32'h0040_0010, 5'd0, 4'b0000, 6'b100001, "jal");
  endtask

  task automatic test_back_to_back();
    logic [3:0] aluc;
    for (int i = 0; i < 24; i++) begin
      do aluc = 4'($urandom_range(0, 15)); while (aluc == 4'b1011);
      issue($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), aluc,
            {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0}, "random");
    end
  endtask

`ifdef EXE_MULT_EN
  task automatic run_mul(input logic [31:0] a, b, input logic [4:0] rn,
                         input bit redrive, input string name);
    int stalls;
    logic [31:0] e;
    if (redrive) drive(a, b, 32'd0, 32'd0, rn, 4'b1011, 6'b100000);
    e = a * b;
    exp_q.push_back(e);
    #1;
    total++;
    if (bus.exe_stall !== 1'b1) begin
      bad++; $display("FAIL %s detect_stall: got %b want 1", name, bus.exe_stall);
    end
    stalls = 0;
    while (bus.exe_stall === 1'b1 && stalls < 100) begin
      @(posedge clk); #1;
      stalls++;
      total++;
      if (bus.mwreg !== 1'b0) begin
        bad++; $display("FAIL %s bubble: got mwreg=%b want 0 at stall %0d", name, bus.mwreg, stalls);
      end
    end
    total++;
    if (stalls != 33) begin
      bad++; $display("FAIL %s stall_cycles: got %0d want 33", name, stalls);
    end
    total++;
    if (bus.ealu_fwd !== e) begin
      bad++; $display("FAIL %s done_fwd: got %h want %h", name, bus.ealu_fwd, e);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (bus.malu !== e || bus.mwreg !== 1'b1 || bus.mrn !== rn) begin
      bad++;
      $display("FAIL %s result: got malu=%h mwreg=%b mrn=%0d want %h 1 %0d",
               name, bus.malu, bus.mwreg, bus.mrn, e, rn);
    end
  endtask

  task automatic test_mul();
    run_mul(32'h0001_0003, 32'h0000_0100, 5'd12, 1'b1, "mul");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b1, "mul_b2b");
    run_mul($urandom, $urandom, 5'd14, 1'b1, "mul_rand");
    issue(32'd2, 32'd9, 32'd0, 32'd0, 5'd15, 4'b0000, 6'b100000, "after_mul");
  endtask

  task automatic test_mul_reset();
    drive(32'd6, 32'd7, 32'd0, 32'd0, 5'd16, 4'b1011, 6'b100000);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mul_state !== 2'd0 || bus.mwreg !== 1'b0) begin
      bad++; $display("FAIL mul_reset: got state=%0d mwreg=%b want 0 0", bus.mul_state, bus.mwreg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(32'd6, 32'd7, 5'd16, 1'b0, "mul_after_reset");
    issue(32'd1, 32'd2, 32'd0, 32'd0, 5'd17, 4'b0000, 6'b100000, "after_mul_reset");
  endtask
`else
  task automatic test_mul_disabled();
    drive(32'd2, 32'd3, 32'd0, 32'd0, 5'd12, 4'b1011, 6'b100000);
    #1;
    total++;
    if (bus.exe_stall !== 1'b0) begin
      bad++; $display("FAIL mul_disabled_stall: got %b want 0", bus.exe_stall);
    end
    issue(32'd2, 32'd3, 32'd0, 32'd0, 5'd12, 4'b1011, 6'b100000, "mul_disabled");
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_arith();
    test_jal();
    test_back_to_back();
`ifdef EXE_MULT_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
